// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - program/run/ALU handshake bundle for alu_sequencer
interface alu_sequencer_if #(
    parameter int AW = 4
);
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [6:0]    prog_wdata;
    logic [AW:0]   prog_len;
    logic          start;
    logic [7:0]    alu_result;
    logic [3:0]    Data;
    logic [2:0]    Function;
    logic          busy;
    logic          done;
    logic [7:0]    result;
    logic [AW:0]   step_count;
`ifdef ALU_SEQUENCER_SINGLE_STEP_EN
    logic          step;

    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, start, alu_result, step,
        input  Data, Function, busy, done, result, step_count
    );
    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, start, alu_result, step,
        output Data, Function, busy, done, result, step_count
    );
`else
    modport master (
        output prog_we, prog_addr, prog_wdata, prog_len, start, alu_result,
        input  Data, Function, busy, done, result, step_count
    );
    modport slave (
        input  prog_we, prog_addr, prog_wdata, prog_len, start, alu_result,
        output Data, Function, busy, done, result, step_count
    );
`endif
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - replays a {Function,Data} program into the ALU accumulator (option: ALU_SEQUENCER_SINGLE_STEP_EN)
module alu_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           Clock,
    input  logic           Reset_b,
    alu_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_W     = (AW + 1)'(1);
    localparam logic [6:0]  HOLD_WORD = 7'b111_0000;

    state_t      state_q, state_d;
    logic [AW:0] pc_q, pc_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] step_count_q, step_count_d;
    logic [7:0]  result_q, result_d;
    logic [6:0]  mem_q [DEPTH];
    logic [6:0]  mem_d [DEPTH];

    logic [AW:0] pc_inc;
    logic [AW:0] len_clamped;
    logic [6:0]  word;
    logic        busy_w;
    logic        done_w;
    logic [2:0]  func_w;
    logic [3:0]  data_w;

    assign busy_w = (state_q == S_ISSUE) || (state_q == S_GAP);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        len_d        = len_q;
        step_count_d = step_count_q;
        result_d     = result_q;
        mem_d        = mem_q;
        done_w       = 1'b0;
        func_w       = 3'b111;
        data_w       = 4'h0;
        pc_inc       = pc_q + ONE_W;
        len_clamped  = (bus.prog_len > DEPTH_W) ? DEPTH_W : bus.prog_len;
        // pc stays below len (<= DEPTH) while in ISSUE, so the low AW bits address the word
        word         = mem_q[pc_q[AW-1:0]];

        if (bus.prog_we && !busy_w) begin
            mem_d[bus.prog_addr] = bus.prog_wdata;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    len_d        = len_clamped;
                    pc_d         = '0;
                    step_count_d = '0;
                    if (len_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
`ifdef ALU_SEQUENCER_SINGLE_STEP_EN
                        state_d = S_GAP;
`else
                        state_d = S_ISSUE;
`endif
                    end
                end
            end
            S_ISSUE: begin
                func_w       = word[6:4];
                data_w       = word[3:0];
                result_d     = bus.alu_result;
                step_count_d = step_count_q + ONE_W;
                pc_d         = pc_inc;
                state_d      = (pc_inc == len_q) ? S_DONE : S_GAP;
            end
            S_GAP: begin
`ifdef ALU_SEQUENCER_SINGLE_STEP_EN
                if (bus.step) begin
                    state_d = S_ISSUE;
                end
`else
                state_d = S_ISSUE;
`endif
            end
            S_DONE: begin
                done_w  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_b) begin
        if (!Reset_b) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            len_q        <= '0;
            step_count_q <= '0;
            result_q     <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= HOLD_WORD;
            end
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            len_q        <= len_d;
            step_count_q <= step_count_d;
            result_q     <= result_d;
            mem_q        <= mem_d;
        end
    end

    assign bus.Function   = func_w;
    assign bus.Data       = data_w;
    assign bus.busy       = busy_w;
    assign bus.done       = done_w;
    assign bus.result     = result_q;
    assign bus.step_count = step_count_q;
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command-side driver for the 4-bit ALU / 8-bit accumulator datapath: it produces the Data/Function stream the accumulator consumes and collects the ALUout it returns.
- Holds a small program of {Function, Data} words, loaded over a write port.
- On start it issues each word for exactly one cycle, holding the accumulator between issues, and captures every result.
- Used in lab top levels in place of switches, so multi-step ALU sequences run unattended.

Parameters:
- DEPTH, 16, number of program words.
- AW, 4, program address width (DEPTH = 2**AW).

Ports:
- Clock  in  1  single system clock, rising edge.
- Reset_b  in  1  asynchronous, active-low reset.
- prog_we  in  1  program write strobe; ignored while busy.
- prog_addr  in  AW  program write address.
- prog_wdata  in  7  [6:4]=Function, [3:0]=Data.
- prog_len  in  AW+1  number of words to run; sampled on the accepted start.
- start  in  1  begin run; ignored unless the FSM is in IDLE.
- alu_result  in  8  ALUout returned by the accumulator datapath.
- Data  out  4  operand A to the ALU.
- Function  out  3  opcode to the ALU.
- busy  out  1  high in ISSUE and GAP.
- done  out  1  one-cycle pulse at the end of a run.
- result  out  8  last captured alu_result.
- step_count  out  AW+1  number of words issued in the current or last run.

Behaviour:
- Reset (Reset_b=0, asynchronous) clears all outputs and state:
  - FSM=IDLE, pc=0, step_count=0, result=8'h00, done=0, busy=0.
  - Data=4'h0, Function=3'b111 (hold).
  - Every program word is cleared to 7'b111_0000.
- Program write: when prog_we=1 and busy=0, mem[prog_addr] <= prog_wdata at the rising edge.
- Outputs outside ISSUE: Function=3'b111 and Data=4'h0, so the accumulator never changes between issues.
- FSM states: IDLE, ISSUE, GAP, DONE.
- IDLE:
  - On start=1, latch len = min(prog_len, DEPTH), clear pc and step_count.
  - If len=0, go to DONE; otherwise go to ISSUE.
- ISSUE (one cycle):
  - Drive {Function, Data} = mem[pc].
  - At the closing edge: result <= alu_result, step_count += 1, pc += 1.
  - If pc+1 == len, go to DONE; otherwise go to GAP.
- GAP (one cycle): hold outputs, then go to ISSUE.
- DONE (one cycle): done=1, busy=0, then go to IDLE.
- Latency:
  - First ISSUE occurs in the cycle after start is sampled.
  - Issue cadence is one word every 2 cycles.
  - The done pulse comes 1 cycle after the last ISSUE.
  - A run of N words takes 2N cycles from start sample to done.
- Boundary conditions:
  - prog_len > DEPTH: clamped to DEPTH; pc never wraps past DEPTH-1.
  - A stored word with Function=3'b111 is still issued and counted; result captures whatever alu_result shows in that cycle.
  - start asserted in DONE is ignored (IDLE only).
  - start held high through IDLE starts a new run immediately.
  - prog_we coincident with an accepted start: the write is applied, since busy=0 on that edge.
  - Reset mid-run: the run aborts immediately, Function returns to hold, and program contents are lost.
- Widths: pc is AW+1 bits internally so comparison with len never aliases; result is stored without modification.

Optional Feature:
- Macro: ALU_SEQUENCER_SINGLE_STEP_EN.
- When defined:
  - Adds an input port step (1 bit).
  - GAP stays in GAP until step=1 is sampled, then goes to ISSUE; the first word also waits in GAP for step.
  - busy stays high while waiting.
- When undefined: no step port; GAP is always exactly one cycle as above.

Test Plan:
- Reset: release Reset_b after 3 cycles -> Function=111, Data=0, result=00, busy=0, done=0, step_count=0.
- Accumulator run (accumulator starts at 0):
  - Program: mem0={001,0011}, mem1={110,0010}, mem2={000,1111}, prog_len=3, pulse start.
  - Required: issues at cycles 1, 3, 5; result goes 03 -> 06 -> 15 (hex); done at cycle 6; step_count=3.
- prog_len=0: pulse start -> done pulse on the next cycle, busy never asserts, result unchanged, step_count=0.
- prog_len=20 with DEPTH=16: exactly 16 issues, done at cycle 32, step_count=16.
- Reset_b dropped during the second GAP -> outputs return to reset values within the same cycle; the next start runs the cleared program (all hold words).
- Macro defined: step held low for 10 cycles after start -> no ISSUE occurs; each step pulse yields exactly one issue.
